// File: rtl/timer_seq_ctrl_if.sv
// Button inputs and display/status outputs of the countdown timer, bundled as one port.
// master drives the raw buttons and observes; slave is the timer itself.
interface timer_seq_ctrl_if;
    logic       btn_inc;
    logic       btn_start;
    logic       btn_clear;
    logic [6:0] seg;
    logic [1:0] dig;
    logic       alarm;
    logic [1:0] state;

    modport master (
        output btn_inc, btn_start, btn_clear,
        input  seg, dig, alarm, state
    );
    modport slave (
        input  btn_inc, btn_start, btn_clear,
        output seg, dig, alarm, state
    );
endinterface

// File: rtl/timer_seq_ctrl.sv
// Two-digit BCD countdown timer: debounced buttons, IDLE/RUN/PAUSE/ALARM FSM, muxed 7-seg display.
// Latency: button action 3+DEBOUNCE_CYC cycles after raw rise; seg/dig combinational from registered state.
// No backpressure: buttons are level inputs; TIMER_ALARM_FLASH_EN adds display flashing in ALARM.
module timer_seq_ctrl #(
    parameter int TICK_DIV     = 6000000,
    parameter int DEBOUNCE_CYC = 16,
    parameter int MUX_DIV      = 1024
) (
    input logic             clk,
    input logic             rst_n,
    timer_seq_ctrl_if.slave io
);
    localparam int PW = $clog2(TICK_DIV);
    localparam int DW = $clog2(DEBOUNCE_CYC + 1);
    localparam int MW = $clog2(MUX_DIV);

    localparam logic [1:0] S_IDLE  = 2'b00;
    localparam logic [1:0] S_RUN   = 2'b01;
    localparam logic [1:0] S_PAUSE = 2'b10;
    localparam logic [1:0] S_ALARM = 2'b11;

    localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);
    localparam logic [DW-1:0] DEB_LAST   = DW'(DEBOUNCE_CYC - 1);

    logic [2:0]    btn_raw;
    logic [2:0]    sync1_q, sync2_q;
    logic [2:0]    deb_lvl_q, deb_lvl_d, deb_prev_q;
    logic [DW-1:0] deb_cnt_q [3];
    logic [DW-1:0] deb_cnt_d [3];
    logic [2:0]    pulse;
    logic          inc_p, start_p, clr_p;

    logic [1:0]    state_q, state_d;
    logic [3:0]    tens_q, tens_d, ones_q, ones_d;
    logic [PW-1:0] presc_q, presc_d;
    logic [MW-1:0] mux_q, mux_d;
    logic          slot_q, slot_d;
    logic          blank;
    logic          tick;
    logic [3:0]    digit_val;
    logic [6:0]    seg_code;

    assign btn_raw = {io.btn_clear, io.btn_start, io.btn_inc};

    // A level flips only after DEBOUNCE_CYC consecutive samples that disagree with it.
    always_comb begin
        deb_lvl_d = deb_lvl_q;
        for (int i = 0; i < 3; i++) begin
            deb_cnt_d[i] = '0;
            if (sync2_q[i] != deb_lvl_q[i]) begin
                if (deb_cnt_q[i] == DEB_LAST) deb_lvl_d[i] = sync2_q[i];
                else                          deb_cnt_d[i] = deb_cnt_q[i] + DW'(1);
            end
        end
    end

    assign pulse   = deb_lvl_q & ~deb_prev_q;
    assign inc_p   = pulse[0];
    assign start_p = pulse[1];
    assign clr_p   = pulse[2];
    assign tick    = (presc_q == PRESC_LAST);

`ifdef TIMER_ALARM_FLASH_EN
    logic blank_q, blank_d;
    assign blank = blank_q;
`else
    assign blank = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        tens_d  = tens_q;
        ones_d  = ones_q;
        presc_d = presc_q;
`ifdef TIMER_ALARM_FLASH_EN
        blank_d = blank_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (clr_p) begin
                    tens_d = 4'd0;
                    ones_d = 4'd0;
                end else if (start_p) begin
                    if (tens_q != 4'd0 || ones_q != 4'd0) begin
                        state_d = S_RUN;
                        presc_d = '0;
                    end
                end else if (inc_p) begin
                    if (ones_q == 4'd9) begin
                        ones_d = 4'd0;
                        tens_d = (tens_q == 4'd9) ? 4'd0 : tens_q + 4'd1;
                    end else begin
                        ones_d = ones_q + 4'd1;
                    end
                end
            end
            S_RUN: begin
                // A terminal tick outranks start, so a pause never swallows the last decrement.
                if (clr_p) begin
                    state_d = S_IDLE;
                    tens_d  = 4'd0;
                    ones_d  = 4'd0;
                    presc_d = '0;
                end else if (tick) begin
                    presc_d = '0;
                    if (ones_q == 4'd0) begin
                        ones_d = 4'd9;
                        tens_d = tens_q - 4'd1;
                    end else begin
                        ones_d = ones_q - 4'd1;
                    end
                    if (tens_q == 4'd0 && ones_q == 4'd1) state_d = S_ALARM;
                end else if (start_p) begin
                    state_d = S_PAUSE;
                end else begin
                    presc_d = presc_q + PW'(1);
                end
            end
            S_PAUSE: begin
                if (clr_p) begin
                    state_d = S_IDLE;
                    tens_d  = 4'd0;
                    ones_d  = 4'd0;
                    presc_d = '0;
                end else if (start_p) begin
                    state_d = S_RUN;
                end
            end
            S_ALARM: begin
                if (pulse != 3'b000) begin
                    state_d = S_IDLE;
                    presc_d = '0;
`ifdef TIMER_ALARM_FLASH_EN
                end else if (tick) begin
                    presc_d = '0;
                    blank_d = ~blank_q;
                end else begin
                    presc_d = presc_q + PW'(1);
`endif
                end
            end
            default: state_d = S_IDLE;
        endcase
`ifdef TIMER_ALARM_FLASH_EN
        if (state_d != S_ALARM) blank_d = 1'b0;
`endif
    end

    always_comb begin
        mux_d  = mux_q + MW'(1);
        slot_d = (mux_q == '1) ? ~slot_q : slot_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q    <= '0;
            sync2_q    <= '0;
            deb_lvl_q  <= '0;
            deb_prev_q <= '0;
            for (int i = 0; i < 3; i++) deb_cnt_q[i] <= '0;
            state_q    <= S_IDLE;
            tens_q     <= 4'd0;
            ones_q     <= 4'd0;
            presc_q    <= '0;
            mux_q      <= '0;
            slot_q     <= 1'b0;
        end else begin
            sync1_q    <= btn_raw;
            sync2_q    <= sync1_q;
            deb_lvl_q  <= deb_lvl_d;
            deb_prev_q <= deb_lvl_q;
            for (int i = 0; i < 3; i++) deb_cnt_q[i] <= deb_cnt_d[i];
            state_q    <= state_d;
            tens_q     <= tens_d;
            ones_q     <= ones_d;
            presc_q    <= presc_d;
            mux_q      <= mux_d;
            slot_q     <= slot_d;
        end
    end

`ifdef TIMER_ALARM_FLASH_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) blank_q <= 1'b0;
        else        blank_q <= blank_d;
    end
`endif

    assign digit_val = slot_q ? tens_q : ones_q;

    always_comb begin
        case (digit_val)
            4'd0:    seg_code = 7'h3F;
            4'd1:    seg_code = 7'h06;
            4'd2:    seg_code = 7'h5B;
            4'd3:    seg_code = 7'h4F;
            4'd4:    seg_code = 7'h66;
            4'd5:    seg_code = 7'h6D;
            4'd6:    seg_code = 7'h7D;
            4'd7:    seg_code = 7'h07;
            4'd8:    seg_code = 7'h7F;
            4'd9:    seg_code = 7'h6F;
            default: seg_code = 7'h00;
        endcase
    end

    assign io.seg   = blank ? 7'h00 : seg_code;
    assign io.dig   = blank ? 2'b00 : (slot_q ? 2'b10 : 2'b01);
    assign io.alarm = (state_q == S_ALARM);
    assign io.state = state_q;
endmodule

// File: tb/tb_timer_seq_ctrl.sv
// Directed bench for timer_seq_ctrl (TICK_DIV=10, DEBOUNCE_CYC=4, MUX_DIV=8); inputs driven and outputs sampled on negedge.
module tb_timer_seq_ctrl;
`ifdef TIMER_ALARM_FLASH_EN
    localparam bit FLASH = 1'b1;
`else
    localparam bit FLASH = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n;
    int   errors = 0;
    int   checks = 0;

    timer_seq_ctrl_if io ();

    timer_seq_ctrl #(.TICK_DIV(10), .DEBOUNCE_CYC(4), .MUX_DIV(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .io    (io)
    );

    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic set_btn(input int b, input logic v);
        case (b)
            0:       io.btn_inc   = v;
            1:       io.btn_start = v;
            default: io.btn_clear = v;
        endcase
    endtask

    // Raw rise here -> action on the 7th rising edge; returns just after that edge.
    task automatic press(input int b);
        set_btn(b, 1'b1);
        cyc(7);
        set_btn(b, 1'b0);
    endtask

    task automatic press_gap(input int b);
        press(b);
        cyc(7);
    endtask

    function automatic logic [3:0] decode(input logic [6:0] s);
        case (s)
            7'h3F: return 4'd0;
            7'h06: return 4'd1;
            7'h5B: return 4'd2;
            7'h4F: return 4'd3;
            7'h66: return 4'd4;
            7'h6D: return 4'd5;
            7'h7D: return 4'd6;
            7'h07: return 4'd7;
            7'h7F: return 4'd8;
            7'h6F: return 4'd9;
            default: return 4'hF;
        endcase
    endfunction

    // Nine samples always span both mux slots; a digit that changes inside the window reads as E.
    task automatic read_count(output logic [7:0] val);
        logic [3:0] t, o, d;
        bit ht, ho;
        t = 4'hF; o = 4'hF; ht = 0; ho = 0;
        for (int i = 0; i < 9; i++) begin
            d = decode(io.seg);
            if (io.dig == 2'b01) begin
                if (!ho) o = d; else if (o != d) o = 4'hE;
                ho = 1;
            end else if (io.dig == 2'b10) begin
                if (!ht) t = d; else if (t != d) t = 4'hE;
                ht = 1;
            end
            cyc(1);
        end
        val = {t, o};
    endtask

    task automatic test_reset();
        logic [7:0] v;
        rst_n = 1'b0;
        io.btn_inc = 1'b0; io.btn_start = 1'b0; io.btn_clear = 1'b0;
        cyc(2);
        checks++; if (io.state !== 2'b00) begin errors++; $display("FAIL rst_state: got %b expected 00", io.state); end
        checks++; if (io.alarm !== 1'b0) begin errors++; $display("FAIL rst_alarm: got %b expected 0", io.alarm); end
        checks++; if (io.dig !== 2'b01 || io.seg !== 7'h3F) begin errors++; $display("FAIL rst_display: got dig=%b seg=%h expected dig=01 seg=3f", io.dig, io.seg); end
        rst_n = 1'b1;
        cyc(2);
        read_count(v);
        checks++; if (v !== 8'h00) begin errors++; $display("FAIL rst_count: got %h expected 00", v); end
    endtask

    task automatic test_countdown();
        logic [7:0] v;
        int bad;
        bit exp_blank;
        repeat (5) press_gap(0);
        read_count(v);
        checks++; if (v !== 8'h05) begin errors++; $display("FAIL set5_count: got %h expected 05", v); end
        press(1);
        checks++; if (io.state !== 2'b01) begin errors++; $display("FAIL run_entry: got %b expected 01", io.state); end
        cyc(49);
        checks++; if (io.state !== 2'b01 || io.alarm !== 1'b0) begin errors++; $display("FAIL pre_alarm: got state=%b alarm=%b expected 01/0", io.state, io.alarm); end
        cyc(1);
        checks++; if (io.state !== 2'b11 || io.alarm !== 1'b1) begin errors++; $display("FAIL alarm_entry: got state=%b alarm=%b expected 11/1", io.state, io.alarm); end
        read_count(v);
        checks++; if (v !== 8'h00) begin errors++; $display("FAIL alarm_count: got %h expected 00", v); end
        bad = 0;
        for (int k = 9; k < 30; k++) begin
            exp_blank = FLASH && (k >= 10) && (k <= 19);
            if ((io.dig == 2'b00) != exp_blank) bad++;
            cyc(1);
        end
        checks++; if (bad !== 0) begin errors++; $display("FAIL alarm_flash_dig: got %0d wrong cycles expected 0", bad); end
        press_gap(2);
        checks++; if (io.state !== 2'b00 || io.alarm !== 1'b0) begin errors++; $display("FAIL alarm_clear: got state=%b alarm=%b expected 00/0", io.state, io.alarm); end
    endtask

    task automatic test_borrow();
        logic [7:0] v;
        repeat (10) press_gap(0);
        read_count(v);
        checks++; if (v !== 8'h10) begin errors++; $display("FAIL set10_count: got %h expected 10", v); end
        press(1);
        cyc(10);
        read_count(v);
        checks++; if (v !== 8'h09) begin errors++; $display("FAIL borrow_count: got %h expected 09", v); end
        checks++; if (io.state !== 2'b01) begin errors++; $display("FAIL borrow_state: got %b expected 01", io.state); end
        press_gap(2);
        read_count(v);
        checks++; if (io.state !== 2'b00 || v !== 8'h00) begin errors++; $display("FAIL run_clear: got state=%b count=%h expected 00/00", io.state, v); end
    endtask

    task automatic test_wrap();
        logic [7:0] v;
        repeat (99) press_gap(0);
        read_count(v);
        checks++; if (v !== 8'h99) begin errors++; $display("FAIL count99: got %h expected 99", v); end
        press_gap(0);
        read_count(v);
        checks++; if (v !== 8'h00) begin errors++; $display("FAIL wrap00: got %h expected 00", v); end
        press_gap(1);
        checks++; if (io.state !== 2'b00) begin errors++; $display("FAIL start_at_zero: got %b expected 00", io.state); end
    endtask

    task automatic test_pause();
        logic [7:0] v;
        repeat (8) press_gap(0);
        press(1);
        cyc(7);
        press(1);
        checks++; if (io.state !== 2'b10) begin errors++; $display("FAIL pause_entry: got %b expected 10", io.state); end
        cyc(40);
        read_count(v);
        checks++; if (v !== 8'h07) begin errors++; $display("FAIL pause_hold_count: got %h expected 07", v); end
        checks++; if (io.state !== 2'b10) begin errors++; $display("FAIL pause_hold_state: got %b expected 10", io.state); end
        press(1);
        checks++; if (io.state !== 2'b01) begin errors++; $display("FAIL resume_state: got %b expected 01", io.state); end
        cyc(7);
        read_count(v);
        checks++; if (v !== 8'h06) begin errors++; $display("FAIL resume_dec: got %h expected 06", v); end
        cyc(50);
        checks++; if (io.state !== 2'b01) begin errors++; $display("FAIL resume_pre_alarm: got %b expected 01", io.state); end
        cyc(1);
        checks++; if (io.state !== 2'b11) begin errors++; $display("FAIL resume_alarm: got %b expected 11", io.state); end
        press_gap(1);
        checks++; if (io.state !== 2'b00) begin errors++; $display("FAIL alarm_start_exit: got %b expected 00", io.state); end
    endtask

    task automatic test_priority();
        logic [7:0] v;
        repeat (3) press_gap(0);
        press(1);
        cyc(4);
        io.btn_start = 1'b1; io.btn_clear = 1'b1;
        cyc(7);
        io.btn_start = 1'b0; io.btn_clear = 1'b0;
        read_count(v);
        checks++; if (io.state !== 2'b00 || v !== 8'h00) begin errors++; $display("FAIL clear_over_start: got state=%b count=%h expected 00/00", io.state, v); end
        cyc(7);
        repeat (2) press_gap(0);
        press(1);
        cyc(13);
        io.btn_start = 1'b1;
        cyc(7);
        io.btn_start = 1'b0;
        checks++; if (io.state !== 2'b11) begin errors++; $display("FAIL tick_over_start: got %b expected 11", io.state); end
        press_gap(0);
        read_count(v);
        checks++; if (io.state !== 2'b00 || v !== 8'h00) begin errors++; $display("FAIL alarm_inc_exit: got state=%b count=%h expected 00/00", io.state, v); end
        io.btn_inc = 1'b1;
        cyc(2);
        io.btn_inc = 1'b0;
        cyc(12);
        read_count(v);
        checks++; if (v !== 8'h00) begin errors++; $display("FAIL glitch_reject: got %h expected 00", v); end
    endtask

    task automatic test_reset_mid();
        logic [7:0] v;
        repeat (3) press_gap(0);
        press(1);
        cyc(5);
        rst_n = 1'b0;
        #1;
        checks++; if (io.state !== 2'b00 || io.alarm !== 1'b0) begin errors++; $display("FAIL midrun_rst_state: got state=%b alarm=%b expected 00/0", io.state, io.alarm); end
        checks++; if (io.dig !== 2'b01 || io.seg !== 7'h3F) begin errors++; $display("FAIL midrun_rst_display: got dig=%b seg=%h expected 01/3f", io.dig, io.seg); end
        io.btn_inc = 1'b1;
        cyc(3);
        rst_n = 1'b1;
        cyc(1);
        checks++; if (io.dig !== 2'b01 || io.seg !== 7'h3F || io.state !== 2'b00) begin errors++; $display("FAIL post_rst_idle: got dig=%b seg=%h state=%b expected 01/3f/00", io.dig, io.seg, io.state); end
        cyc(19);
        read_count(v);
        checks++; if (v !== 8'h01) begin errors++; $display("FAIL held_btn_once: got %h expected 01", v); end
        io.btn_inc = 1'b0;
        cyc(10);
        read_count(v);
        checks++; if (v !== 8'h01) begin errors++; $display("FAIL held_btn_release: got %h expected 01", v); end
    endtask

    initial begin
        test_reset();
        test_countdown();
        test_borrow();
        test_wrap();
        test_pause();
        test_priority();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/timer_seq_ctrl.md
TIMER_SEQ_CTRL -- requirements
Module: timer_seq_ctrl

Interface
REQ-001 Parameter TICK_DIV, default 6000000, clk cycles per countdown second (>=2).
REQ-002 Parameter DEBOUNCE_CYC, default 16, stable cycles required to accept a button level (>=1).
REQ-003 Parameter MUX_DIV, default 1024, clk cycles per display-digit slot (power of two, >=2).
REQ-004 clk  input  1  single clock, all state on rising edge.
REQ-005 rst_n  input  1  asynchronous active-low reset.
REQ-006 btn_inc  input  1  raw asynchronous button, add one to setpoint.
REQ-007 btn_start  input  1  raw asynchronous button, start/pause toggle.
REQ-008 btn_clear  input  1  raw asynchronous button, abort and zero.
REQ-009 seg  output  7  segment drive {g,f,e,d,c,b,a}, active high.
REQ-010 dig  output  2  digit enables {tens,ones}, one-hot or 00 when blanked.
REQ-011 alarm  output  1  high while in ALARM.
REQ-012 state  output  2  IDLE=00, RUN=01, PAUSE=10, ALARM=11.

Function
REQ-013 Each button SHALL pass a 2-FF synchronizer, then a debouncer that updates its level only after DEBOUNCE_CYC consecutive identical synchronized samples; action pulse = debounced rising edge (one cycle), issued 2+DEBOUNCE_CYC to 3+DEBOUNCE_CYC cycles after the raw rise.
REQ-014 Count SHALL be two BCD digits (tens, ones), each 0..9, never holding 10..15.
REQ-015 Priority when pulses coincide: clear > start > inc.
REQ-016 IDLE: inc -> count+1, 99 wraps to 00; start with count!=00 -> RUN with prescaler=0; start with count==00 -> no-op; clear -> count=00.
REQ-017 RUN: prescaler counts 0..TICK_DIV-1; at TICK_DIV-1 it wraps to 0 and count decrements (x0 -> (x-1)9); decrement producing 00 -> ALARM on the same edge; start -> PAUSE; clear -> IDLE, count=00; inc ignored.
REQ-018 PAUSE: prescaler and count frozen; start -> RUN, prescaler resumes from held value; clear -> IDLE, count=00; inc ignored.
REQ-019 ALARM: count=00, alarm=1; any button pulse -> IDLE, alarm=0 next cycle.
REQ-020 A start pulse on the same cycle as a terminal tick in RUN: the tick is applied (decrement/ALARM entry) and start is ignored.
REQ-021 Display: free-running mux counter of width log2(MUX_DIV); slot toggles on wrap; slot 0 -> dig=01 with ones code, slot 1 -> dig=10 with tens code.
REQ-022 Segment codes 0..9 SHALL be 3F,06,5B,4F,66,6D,7D,07,7F,6F (hex, a=bit0); seg and dig combinational from registered count/slot/blank.
REQ-023 When blanked, seg=00 and dig=00.

Reset
REQ-024 rst_n low SHALL immediately force: state=IDLE, count=00, prescaler=0, mux counter=0, slot=0, synchronizers/debouncers=0, blank=0, alarm=0.
REQ-025 Reset asserted mid-RUN or mid-ALARM SHALL discard the countdown; after release the outputs are those of IDLE with 00 (dig=01, seg=3F).
REQ-026 A button held low-to-high across reset release SHALL generate exactly one action pulse after debounce.

Configuration
REQ-027 Macro TIMER_ALARM_FLASH_EN defined: in ALARM, blank toggles each time the prescaler wraps (period 2*TICK_DIV, starting unblanked on ALARM entry); blank=0 outside ALARM.
REQ-028 Macro TIMER_ALARM_FLASH_EN undefined: blank is constant 0 and ALARM shows steady 00; flash logic is absent.

Verification (TICK_DIV=10, DEBOUNCE_CYC=4, MUX_DIV=8)
REQ-029 Reset, 5 inc presses, start -> state=01; after 50 cycles count=00, state=11, alarm=1.
REQ-030 Set 10, start, 10 cycles -> count 09 (tens borrow), state=01.
REQ-031 100 inc presses from 00 -> count=00 (wrap); start at 00 -> state stays 00.
REQ-032 RUN at 07, start after 3 prescaler cycles, hold 40 cycles -> count stays 07; start again -> decrement 7 cycles later.
REQ-033 start and clear pulsed in the same cycle in RUN -> state=00, count=00; 2-cycle glitch on btn_inc -> no increment.
REQ-034 In ALARM with TIMER_ALARM_FLASH_EN defined: dig=00 for cycles 10..19 after entry, then nonzero again; undefined: dig never 00.
